// File: rtl/scratchpad_pkg.sv
// Shared types and constants for the banked scratchpad: clear-engine
// state encoding and byte-lane helpers.
package scratchpad_pkg;

   // Clear engine states
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Lane count for the default 8-bit word; wider instances use lanes_of()
   localparam int DEFAULT_WIDTH = 8;
   localparam int NUM_LANES     = DEFAULT_WIDTH / 8;

   // Number of byte lanes in a word of the given width
   function automatic int lanes_of(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/scratchpad_bank.sv
// One DEPTH x WIDTH bank built from independent byte-lane memories so each
// strobe maps onto its own RAM write enable. Read is synchronous and
// returns the pre-write word on a same-row collision.
module scratchpad_bank
   import scratchpad_pkg::*;
#(
   parameter int DEPTH     = 32,
   parameter int LOG_DEPTH = 5,
   parameter int WIDTH     = 8
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [WIDTH/8-1:0]     wstrb,
   input  logic [LOG_DEPTH-1:0]   waddr,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   ren,
   input  logic [LOG_DEPTH-1:0]   raddr,
   output logic [WIDTH-1:0]       rdata
);

   localparam int LANES = lanes_of(WIDTH);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] q_reg;

         // Byte-lane write, gated by its strobe
         always_ff @(posedge clk) begin
            if (we && wstrb[gi]) begin
               mem[waddr] <= wdata[gi*8 +: 8];
            end
         end

         // Registered read of this lane
         always_ff @(posedge clk) begin
            if (ren) begin
               q_reg <= mem[raddr];
            end
         end

         assign rdata[gi*8 +: 8] = q_reg;
      end
   endgenerate

endmodule

// File: rtl/banked_scratchpad.sv
// Low-order-interleaved multi-bank scratchpad with byte-strobed writes,
// selectable read-during-write policy, optional output register and a
// clear engine that zeroes one row of every bank per cycle.
module banked_scratchpad
   import scratchpad_pkg::*;
#(
   parameter int DEPTH       = 32,
   parameter int LOG_DEPTH   = 5,
   parameter int WIDTH       = 8,
   parameter int BANKS       = 4,
   parameter int LOG_BANKS   = 2,
   parameter int OUT_REG     = 0,
   parameter int WRITE_FIRST = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr_start,
   output logic                           busy,
   input  logic                           ren,
   input  logic [LOG_DEPTH+LOG_BANKS-1:0] raddr,
   output logic [WIDTH-1:0]               rdata,
   output logic                           rvalid,
   input  logic                           we,
   input  logic [WIDTH/8-1:0]             wstrb,
   input  logic [LOG_DEPTH+LOG_BANKS-1:0] waddr,
   input  logic [WIDTH-1:0]               wdata,
   output logic                           wready
);

   localparam int LANES = lanes_of(WIDTH);
   localparam int AW    = LOG_DEPTH + LOG_BANKS;

   clr_state_t           state_reg, state_next;
   logic [LOG_DEPTH-1:0] cnt_reg, cnt_next;
   logic                 clearing;

   logic [LOG_BANKS-1:0] wbank, rbank;
   logic [LOG_DEPTH-1:0] wrow, rrow;
   logic                 wr_ok;

   logic [LOG_DEPTH-1:0] bank_row;
   logic [LANES-1:0]     bank_strb;
   logic [WIDTH-1:0]     bank_data;
   logic [WIDTH-1:0]     bank_q [BANKS];

   logic                 byp_hit;
   logic [LANES-1:0]     byp_strb;
   logic [WIDTH-1:0]     byp_data;

   logic                 s1_valid_reg;
   logic [LOG_BANKS-1:0] s1_bank_reg;
   logic                 byp_hit_reg;
   logic [LANES-1:0]     byp_strb_reg;
   logic [WIDTH-1:0]     byp_data_reg;
   logic [WIDTH-1:0]     s1_data;

   assign clearing = (state_reg == CLEAR);
   assign busy     = clearing;
   assign wready   = ~clearing;

   assign wbank = waddr[LOG_BANKS-1:0];
   assign wrow  = waddr[AW-1:LOG_BANKS];
   assign rbank = raddr[LOG_BANKS-1:0];
   assign rrow  = raddr[AW-1:LOG_BANKS];
   assign wr_ok = we && !clearing;

   // The clear engine owns every bank's write port while it runs
   assign bank_row  = clearing ? cnt_reg : wrow;
   assign bank_strb = clearing ? {LANES{1'b1}} : wstrb;
   assign bank_data = clearing ? '0 : wdata;

   genvar gi;
   generate
      for (gi = 0; gi < BANKS; gi++) begin : g_bank
         logic bank_we;
         logic bank_ren;

         assign bank_we  = clearing || (wr_ok && (wbank == LOG_BANKS'(gi)));
         assign bank_ren = ren && (rbank == LOG_BANKS'(gi));

         scratchpad_bank #(
            .DEPTH     (DEPTH),
            .LOG_DEPTH (LOG_DEPTH),
            .WIDTH     (WIDTH)
         ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .wstrb (bank_strb),
            .waddr (bank_row),
            .wdata (bank_data),
            .ren   (bank_ren),
            .raddr (rrow),
            .rdata (bank_q[gi])
         );
      end
   endgenerate

   // Clear FSM state and row counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Clear FSM next state: one row per cycle, exit after the last row
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (clr_start) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         CLEAR: begin
            if (cnt_reg == LOG_DEPTH'(DEPTH - 1)) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Same-address forwarding for the write-first policy; a clear row hit
   // forwards zero on every lane of every bank
   always_comb begin
      byp_hit  = 1'b0;
      byp_strb = '0;
      byp_data = '0;
      if (WRITE_FIRST != 0) begin
         if (clearing) begin
            byp_hit  = (rrow == cnt_reg);
            byp_strb = {LANES{1'b1}};
         end else if (wr_ok && (waddr == raddr)) begin
            byp_hit  = 1'b1;
            byp_strb = wstrb;
            byp_data = wdata;
         end
      end
   end

   // Read stage 1: remember which bank answers and any forwarded bytes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_bank_reg  <= '0;
         byp_hit_reg  <= 1'b0;
         byp_strb_reg <= '0;
         byp_data_reg <= '0;
      end else begin
         s1_valid_reg <= ren;
         if (ren) begin
            s1_bank_reg  <= rbank;
            byp_hit_reg  <= byp_hit;
            byp_strb_reg <= byp_strb;
            byp_data_reg <= byp_data;
         end
      end
   end

   generate
      for (gi = 0; gi < LANES; gi++) begin : g_merge
         assign s1_data[gi*8 +: 8] = (byp_hit_reg && byp_strb_reg[gi]) ?
                                     byp_data_reg[gi*8 +: 8] :
                                     bank_q[s1_bank_reg][gi*8 +: 8];
      end

      if (OUT_REG != 0) begin : g_oreg
         logic             out_valid_reg;
         logic [WIDTH-1:0] out_data_reg;

         // Output pipeline register; data holds while no read completes
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid_reg <= 1'b0;
               out_data_reg  <= '0;
            end else begin
               out_valid_reg <= s1_valid_reg;
               if (s1_valid_reg) begin
                  out_data_reg <= s1_data;
               end
            end
         end

         assign rvalid = out_valid_reg;
         assign rdata  = out_data_reg;
      end else begin : g_noreg
         logic [WIDTH-1:0] hold_reg;

         // Keep the last delivered word so rdata is stable between reads
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hold_reg <= '0;
            end else if (s1_valid_reg) begin
               hold_reg <= s1_data;
            end
         end

         assign rvalid = s1_valid_reg;
         assign rdata  = s1_valid_reg ? s1_data : hold_reg;
      end
   endgenerate

endmodule
